// File: rtl/timer_pkg.sv
// Shared encodings and control-word helpers for the three-channel timer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package timer_pkg;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_SQUARE   = 2'b10;
  localparam logic [1:0] SEL_CTRL      = 2'b11;

  localparam int CTRL_BITS_PER_CH = 3;
  localparam int NUM_CH           = 3;
  localparam int CTRL_W           = CTRL_BITS_PER_CH * NUM_CH;

  // Per-channel slice of the control word: {enable, mode[1:0]}.
  typedef struct packed {
    logic       enable;
    logic [1:0] mode;
  } ch_ctrl_t;

  // Extract the control slice of one channel from the packed control word.
  function automatic ch_ctrl_t ch_ctrl_of(input logic [CTRL_W-1:0] ctrl, input int ch);
    return ctrl[ch*CTRL_BITS_PER_CH +: CTRL_BITS_PER_CH];
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counter channel: reload/count/out state with one-shot, periodic and square modes.
// Latency: state updates on the posedge after load/tick; count_nxt shows the value being registered.
// Backpressure: none; ticks are consumed or dropped in the cycle they arrive.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [CNT_W-1:0] count_nxt,
  output logic             out
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] count;
  logic             pulse;
  logic [CNT_W-1:0] reload_nxt;
  logic             out_nxt;
  logic             pulse_nxt;
  logic             is_oneshot;

  // Reserved mode 11 falls through to one-shot behaviour.
  assign is_oneshot = (mode != MODE_PERIODIC) && (mode != MODE_SQUARE);

  // Next-state: a load beats any tick; decrements stop at zero; expiry action depends on mode.
  always_comb begin
    reload_nxt = reload;
    count_nxt  = count;
    out_nxt    = out;
    pulse_nxt  = 1'b0;
    if (load) begin
      reload_nxt = load_val;
      count_nxt  = load_val;
      out_nxt    = 1'b0;
    end else begin
      // A periodic pulse is exactly one cycle wide, even if the channel is disabled meanwhile;
      // tracking it separately keeps a level inherited from a mode change untouched.
      if (pulse) out_nxt = 1'b0;
      if (enable) begin
        if (count == '0) begin
          if (is_oneshot) out_nxt = 1'b1;
        end else if (tick) begin
          if (count == ONE) begin
            case (mode)
              MODE_PERIODIC: begin
                count_nxt = reload;
                out_nxt   = 1'b1;
                pulse_nxt = 1'b1;
              end
              MODE_SQUARE: begin
                count_nxt = reload;
                out_nxt   = ~out;
              end
              default: begin
                count_nxt = '0;
                out_nxt   = 1'b1;
              end
            endcase
          end else begin
            count_nxt = count - ONE;
          end
        end
      end
    end
  end

  // Channel state register; async reset clears everything including a pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload <= '0;
      count  <= '0;
      out    <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      reload <= reload_nxt;
      count  <= count_nxt;
      out    <= out_nxt;
      pulse  <= pulse_nxt;
    end
  end

endmodule

// File: rtl/timer_counter3.sv
// Three-channel programmable down-counter with control register and registered read-back.
// Latency: writes take effect at the strobe edge; counter_out is registered one edge after select.
// Backpressure: none; writes and ticks are accepted every cycle, a write to a channel drops its tick.
module timer_counter3
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              counter_we,
  input  logic [1:0]        counter_set,
  input  logic [31:0]       counter_val,
  input  logic [2:0]        tick_in,
  output logic              counter0_out,
  output logic              counter1_out,
  output logic              counter2_out,
  output logic [31:0]       counter_out
);

  logic [CTRL_W-1:0] ctrl;
  logic [CTRL_W-1:0] ctrl_nxt;
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] ch_out;
  logic [31:0]       rd_nxt;

  // Control word update; channels keep seeing the old value until the next edge.
  always_comb begin
    ctrl_nxt = ctrl;
    if (counter_we && counter_set == SEL_CTRL) ctrl_nxt = counter_val[CTRL_W-1:0];
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_ctrl_t cfg;
    assign cfg = ch_ctrl_of(ctrl, g);

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (counter_we && counter_set == 2'(g)),
      .load_val  (counter_val[CNT_W-1:0]),
      .tick      (tick_in[g]),
      .enable    (cfg.enable),
      .mode      (cfg.mode),
      .count_nxt (cnt_nxt[g]),
      .out       (ch_out[g])
    );
  end

  assign counter0_out = ch_out[0];
  assign counter1_out = ch_out[1];
  assign counter2_out = ch_out[2];

  // Read mux uses post-update values so a read shows the count as of this edge.
  always_comb begin
    rd_nxt = '0;
    case (counter_set)
      2'd0:     rd_nxt[CNT_W-1:0]  = cnt_nxt[0];
      2'd1:     rd_nxt[CNT_W-1:0]  = cnt_nxt[1];
      2'd2:     rd_nxt[CNT_W-1:0]  = cnt_nxt[2];
      default:  rd_nxt[CTRL_W-1:0] = ctrl_nxt;
    endcase
  end

  // Control and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl        <= '0;
      counter_out <= '0;
    end else begin
      ctrl        <= ctrl_nxt;
      counter_out <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_timer_counter3.sv
// Self-checking bench for timer_counter3: reset, one-shot, periodic, square, collisions, limits.
// Latency: expectations are queued per cycle and compared one edge later.
// Backpressure: n/a.
module tb_timer_counter3;

  logic        clk = 1'b0;
  logic        rst;
  logic        counter_we;
  logic [1:0]  counter_set;
  logic [31:0] counter_val;
  logic [2:0]  tick_in;
  logic        counter0_out, counter1_out, counter2_out;
  logic [31:0] counter_out;
  logic [2:0]  outs;

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] exp_cnt_q [$];
  logic [2:0]  exp_out_q [$];

  assign outs = {counter2_out, counter1_out, counter0_out};

  always #5 clk = ~clk;

  timer_counter3 #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .counter_we   (counter_we),
    .counter_set  (counter_set),
    .counter_val  (counter_val),
    .tick_in      (tick_in),
    .counter0_out (counter0_out),
    .counter1_out (counter1_out),
    .counter2_out (counter2_out),
    .counter_out  (counter_out)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [31:0] val);
    counter_set = sel;
    counter_val = val;
    counter_we  = 1'b1;
    cyc();
    counter_we  = 1'b0;
  endtask

  task automatic test_reset();
    counter_we = 1'b0; counter_set = 2'd0; counter_val = '0; tick_in = '0;
    rst = 1'b1;
    repeat (2) cyc();
    n_checks++;
    if (counter_out !== 32'd0 || outs !== 3'b000) begin
      n_errs++;
      $display("FAIL reset_state: counter_out=%0h outs=%b, required 0 and 000", counter_out, outs);
    end
    rst = 1'b0;
    cyc();
    write_reg(2'd0, 32'd5);
    write_reg(2'd1, 32'd1);
    write_reg(2'd3, 32'h024);
    tick_in = 3'b010;
    cyc();
    tick_in = 3'b000;
    counter_set = 2'd0;
    cyc();
    n_checks++;
    if (counter_out !== 32'd5 || outs !== 3'b010) begin
      n_errs++;
      $display("FAIL pre_reset: counter_out=%0d outs=%b, required 5 and 010", counter_out, outs);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (counter_out !== 32'd0 || outs !== 3'b000) begin
      n_errs++;
      $display("FAIL async_reset: counter_out=%0d outs=%b, required 0 and 000", counter_out, outs);
    end
    #1 rst = 1'b0;
    cyc();
    n_checks++;
    if (counter_out !== 32'd0) begin
      n_errs++;
      $display("FAIL reset_count0: counter_out=%0d, required 0", counter_out);
    end
    counter_set = 2'd3;
    cyc();
    n_checks++;
    if (counter_out !== 32'd0) begin
      n_errs++;
      $display("FAIL reset_ctrl: counter_out=%0h, required 0", counter_out);
    end
  endtask

  task automatic test_oneshot();
    write_reg(2'd0, 32'd3);
    write_reg(2'd3, 32'h004);
    counter_set = 2'd0;
    tick_in = 3'b001;
    for (int i = 0; i < 13; i++) begin
      exp_cnt_q.push_back(i < 3 ? 32'(2 - i) : 32'd0);
      exp_out_q.push_back(i >= 2 ? 3'b001 : 3'b000);
      cyc();
      begin
        logic [31:0] ec;
        logic [2:0]  eo;
        ec = exp_cnt_q.pop_front();
        eo = exp_out_q.pop_front();
        n_checks++;
        if (counter_out !== ec || outs !== eo) begin
          n_errs++;
          $display("FAIL oneshot tick %0d: count=%0d outs=%b, required count=%0d outs=%b",
                   i, counter_out, outs, ec, eo);
        end
      end
    end
    tick_in = 3'b000;
    write_reg(2'd0, 32'd3);
    n_checks++;
    if (counter_out !== 32'd3 || outs !== 3'b000) begin
      n_errs++;
      $display("FAIL oneshot_rewrite: count=%0d outs=%b, required 3 and 000", counter_out, outs);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] cnt_tab [9] = '{32'd3, 32'd2, 32'd1, 32'd4, 32'd3, 32'd2, 32'd1, 32'd4, 32'd3};
    logic        pul_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    write_reg(2'd1, 32'd4);
    n_checks++;
    if (counter_out !== 32'd4) begin
      n_errs++;
      $display("FAIL periodic_load: count=%0d, required 4", counter_out);
    end
    write_reg(2'd3, 32'h028);
    counter_set = 2'd1;
    tick_in = 3'b010;
    for (int i = 0; i < 9; i++) begin
      exp_cnt_q.push_back(cnt_tab[i]);
      exp_out_q.push_back({1'b0, pul_tab[i], 1'b0});
      cyc();
      begin
        logic [31:0] ec;
        logic [2:0]  eo;
        ec = exp_cnt_q.pop_front();
        eo = exp_out_q.pop_front();
        n_checks++;
        if (counter_out !== ec || outs !== eo) begin
          n_errs++;
          $display("FAIL periodic tick %0d: count=%0d outs=%b, required count=%0d outs=%b",
                   i, counter_out, outs, ec, eo);
        end
      end
    end
    tick_in = 3'b000;
  endtask

  task automatic test_square();
    write_reg(2'd2, 32'd2);
    write_reg(2'd3, 32'h180);
    counter_set = 2'd2;
    tick_in = 3'b100;
    for (int i = 0; i < 8; i++) begin
      exp_cnt_q.push_back((i % 2 == 0) ? 32'd1 : 32'd2);
      exp_out_q.push_back((i % 4 == 1 || i % 4 == 2) ? 3'b100 : 3'b000);
      cyc();
      begin
        logic [31:0] ec;
        logic [2:0]  eo;
        ec = exp_cnt_q.pop_front();
        eo = exp_out_q.pop_front();
        n_checks++;
        if (counter_out !== ec || outs !== eo) begin
          n_errs++;
          $display("FAIL square tick %0d: count=%0d outs=%b, required count=%0d outs=%b",
                   i, counter_out, outs, ec, eo);
        end
      end
    end
    tick_in = 3'b000;
  endtask

  task automatic test_back_to_back();
    write_reg(2'd3, 32'h028);
    counter_set = 2'd1; counter_val = 32'd7; counter_we = 1'b1; tick_in = 3'b010;
    cyc();
    counter_we = 1'b0;
    n_checks++;
    if (counter_out !== 32'd7) begin
      n_errs++;
      $display("FAIL write_beats_tick: count=%0d, required 7", counter_out);
    end
    cyc();
    n_checks++;
    if (counter_out !== 32'd6) begin
      n_errs++;
      $display("FAIL tick_after_write: count=%0d, required 6", counter_out);
    end
    counter_set = 2'd3; counter_val = 32'h000; counter_we = 1'b1;
    cyc();
    counter_we = 1'b0;
    n_checks++;
    if (counter_out !== 32'h000) begin
      n_errs++;
      $display("FAIL ctrl_disable_read: ctrl=%0h, required 0", counter_out);
    end
    counter_set = 2'd1;
    cyc();
    n_checks++;
    if (counter_out !== 32'd5) begin
      n_errs++;
      $display("FAIL ctrl_old_enable: count=%0d, required 5", counter_out);
    end
    tick_in = 3'b000;
  endtask

  task automatic test_zero_and_wrap();
    write_reg(2'd1, 32'd0);
    write_reg(2'd2, 32'd0);
    write_reg(2'd0, 32'hFFFF_FFFF);
    n_checks++;
    if (counter_out !== 32'hFFFF_FFFF) begin
      n_errs++;
      $display("FAIL max_load: count=%0h, required ffffffff", counter_out);
    end
    write_reg(2'd3, 32'h12C);
    n_checks++;
    if (counter_out !== 32'h12C || outs !== 3'b000) begin
      n_errs++;
      $display("FAIL ctrl_write: ctrl=%0h outs=%b, required 12c and 000", counter_out, outs);
    end
    counter_set = 2'd0;
    tick_in = 3'b001;
    for (int i = 0; i < 3; i++) begin
      exp_cnt_q.push_back(32'hFFFF_FFFE - 32'(i));
      exp_out_q.push_back(3'b100);
      cyc();
      begin
        logic [31:0] ec;
        logic [2:0]  eo;
        ec = exp_cnt_q.pop_front();
        eo = exp_out_q.pop_front();
        n_checks++;
        if (counter_out !== ec || outs !== eo) begin
          n_errs++;
          $display("FAIL max_count tick %0d: count=%0h outs=%b, required count=%0h outs=%b",
                   i, counter_out, outs, ec, eo);
        end
      end
    end
    counter_set = 2'd1;
    tick_in = 3'b010;
    for (int i = 0; i < 3; i++) begin
      exp_cnt_q.push_back(32'd0);
      exp_out_q.push_back(3'b100);
      cyc();
      begin
        logic [31:0] ec;
        logic [2:0]  eo;
        ec = exp_cnt_q.pop_front();
        eo = exp_out_q.pop_front();
        n_checks++;
        if (counter_out !== ec || outs !== eo) begin
          n_errs++;
          $display("FAIL periodic_zero tick %0d: count=%0h outs=%b, required count=%0h outs=%b",
                   i, counter_out, outs, ec, eo);
        end
      end
    end
    tick_in = 3'b000;
    counter_set = 2'd3;
    cyc();
    n_checks++;
    if (counter_out !== 32'h12C) begin
      n_errs++;
      $display("FAIL ctrl_read: ctrl=%0h, required 12c", counter_out);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_square();
    test_back_to_back();
    test_zero_and_wrap();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
